// File: rtl/tdm_demux_8.sv
// Receive side of the 8-slot TDM link: realigns on the slot-0 sync marker and
// presents each completed frame as a registered parallel bus.
module tdm_demux_8 #(
    parameter int WIDTH = 1,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [8*WIDTH-1:0]   dout,
    output logic                 frame_valid,
    output logic                 locked,
    output logic [2:0]           slot,
    output logic                 sync_err,
    output logic [ERR_W-1:0]     err_cnt
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           slot_reg, slot_next;
    logic [8*WIDTH-1:0]   shadow_reg, shadow_next;
    logic [8*WIDTH-1:0]   dout_reg;
    logic                 frame_valid_reg;
    logic                 sync_err_reg;
    logic [ERR_W-1:0]     err_cnt_reg;

    logic                 shadow_we;
    logic [2:0]           wr_slot;
    logic                 load_dout;
    logic                 err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HUNT;
            slot_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        shadow_we  = 1'b0;
        wr_slot    = slot_reg;
        load_dout  = 1'b0;
        err_next   = 1'b0;
        if (din_valid) begin
            case (state_reg)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_we  = 1'b1;
                        wr_slot    = 3'd0;
                        slot_next  = 3'd1;
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // An early sync restarts the frame rather than dropping lock.
                        shadow_we = 1'b1;
                        wr_slot   = 3'd0;
                        slot_next = 3'd1;
                        err_next  = (slot_reg != 3'd0);
                    end else if (slot_reg == 3'd0) begin
                        err_next   = 1'b1;
                        slot_next  = 3'd0;
                        state_next = HUNT;
                    end else begin
                        shadow_we = 1'b1;
                        wr_slot   = slot_reg;
                        slot_next = slot_reg + 3'd1;
                        load_dout = (slot_reg == 3'd7);
                    end
                end
                default: begin
                    state_next = HUNT;
                    slot_next  = 3'd0;
                end
            endcase
        end
    end

    // Per-slot write steering into the shadow frame.
    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        assign shadow_next[gi*WIDTH +: WIDTH] =
            (shadow_we && (wr_slot == 3'(gi))) ? din : shadow_reg[gi*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg      <= '0;
            dout_reg        <= '0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            err_cnt_reg     <= '0;
        end else begin
            shadow_reg      <= shadow_next;
            frame_valid_reg <= load_dout;
            sync_err_reg    <= err_next;
            if (load_dout) begin
                dout_reg <= {din, shadow_reg[7*WIDTH-1:0]};
            end
            if (err_next && (err_cnt_reg != {ERR_W{1'b1}})) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign dout        = dout_reg;
    assign frame_valid = frame_valid_reg;
    assign locked      = (state_reg == LOCKED);
    assign slot        = slot_reg;
    assign sync_err    = sync_err_reg;
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed bench for tdm_demux_8: table of frame vectors plus hand-written
// sequences for sync errors, mid-frame reset and counter saturation.
module tb_tdm_demux_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;

    logic [7:0] dout;
    logic       frame_valid, locked, sync_err;
    logic [2:0] slot;
    logic [7:0] err_cnt;

    logic [7:0] dout2;
    logic       frame_valid2, locked2, sync_err2;
    logic [2:0] slot2;
    logic [1:0] err_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_demux_8 #(.WIDTH(1), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .dout(dout), .frame_valid(frame_valid), .locked(locked), .slot(slot),
        .sync_err(sync_err), .err_cnt(err_cnt)
    );

    // Narrow error counter copy, used for the saturation corner.
    tdm_demux_8 #(.WIDTH(1), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .dout(dout2), .frame_valid(frame_valid2), .locked(locked2), .slot(slot2),
        .sync_err(sync_err2), .err_cnt(err_cnt2)
    );

    typedef struct {
        logic       v;
        logic       s;
        logic       d;
        logic       fv;
        logic       se;
        logic       lk;
        logic [2:0] sl;
        logic [7:0] dout;
    } vec_t;

    vec_t vec [64];
    int   nvec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic fv, input logic se, input logic lk,
                           input logic [2:0] sl, input logic [7:0] dv, input logic [7:0] ec);
        chk({tag, "_fv"},   32'(frame_valid), 32'(fv));
        chk({tag, "_se"},   32'(sync_err),    32'(se));
        chk({tag, "_lk"},   32'(locked),      32'(lk));
        chk({tag, "_slot"}, 32'(slot),        32'(sl));
        chk({tag, "_dout"}, 32'(dout),        32'(dv));
        chk({tag, "_ecnt"}, 32'(err_cnt),     32'(ec));
    endtask

    task automatic step(input logic v, input logic s, input logic d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fdata [4];
        logic [7:0] prev;
        logic [7:0] fe;
        int         k1;

        // slot k of each frame is bit k; the rebuilt dout equals the packed byte
        fdata[0] = 8'b01001101;
        fdata[1] = 8'b10010110;
        fdata[2] = 8'b00001111;
        fdata[3] = 8'b01001101;
        nvec = 0;
        prev = 8'h00;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin
                vec[nvec].v    = 1'b1;
                vec[nvec].s    = (k == 0);
                vec[nvec].d    = fdata[f][k];
                vec[nvec].fv   = (k == 7);
                vec[nvec].se   = 1'b0;
                vec[nvec].lk   = 1'b1;
                vec[nvec].sl   = 3'((k + 1) % 8);
                vec[nvec].dout = (k == 7) ? fdata[f] : prev;
                nvec++;
                if (f == 3) begin
                    // idle beat carrying junk and a stray sync, both must be ignored
                    vec[nvec].v    = 1'b0;
                    vec[nvec].s    = 1'b1;
                    vec[nvec].d    = ~fdata[f][k];
                    vec[nvec].fv   = 1'b0;
                    vec[nvec].se   = 1'b0;
                    vec[nvec].lk   = 1'b1;
                    vec[nvec].sl   = 3'((k + 1) % 8);
                    vec[nvec].dout = (k == 7) ? fdata[f] : prev;
                    nvec++;
                end
                if (k == 7) prev = fdata[f];
            end
        end

        rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            step(vec[i].v, vec[i].s, vec[i].d);
            chk_all($sformatf("vec%0d", i), vec[i].fv, vec[i].se, vec[i].lk,
                    vec[i].sl, vec[i].dout, 8'd0);
            $display("vec%0d v=%0b s=%0b d=%0b -> fv=%0b slot=%0d dout=%02h",
                     i, vec[i].v, vec[i].s, vec[i].d, frame_valid, slot, dout);
        end

        // Early sync on the 5th beat: partial frame dropped, beat becomes slot 0.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk_all("pre_early", 1'b0, 1'b0, 1'b1, 3'd4, 8'h4D, 8'd0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("early_sync", 1'b0, 1'b1, 1'b1, 3'd1, 8'h4D, 8'd1);
        $display("early sync -> sync_err=%0b err_cnt=%0d", sync_err, err_cnt);
        fe = 8'h3C;
        for (int k = 1; k < 8; k++) begin
            k1 = (k + 1) % 8;
            step(1'b1, 1'b0, fe[k]);
            chk_all($sformatf("resync%0d", k), (k == 7), 1'b0, 1'b1, 3'(k1),
                    (k == 7) ? 8'h3C : 8'h4D, 8'd1);
        end
        $display("resync frame -> dout=%02h fv=%0b", dout, frame_valid);

        // Missing sync after a full frame drops lock; non-sync beats then ignored.
        step(1'b1, 1'b0, 1'b1);
        chk_all("miss_sync", 1'b0, 1'b1, 1'b0, 3'd0, 8'h3C, 8'd2);
        chk("miss_sync_ecnt2", 32'(err_cnt2), 32'd2);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1);
            chk_all($sformatf("hunt%0d", k), 1'b0, 1'b0, 1'b0, 3'd0, 8'h3C, 8'd2);
        end
        step(1'b1, 1'b1, 1'b1);
        chk_all("relock", 1'b0, 1'b0, 1'b1, 3'd1, 8'h3C, 8'd2);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk_all("pre_rst", 1'b0, 1'b0, 1'b1, 3'd4, 8'h3C, 8'd2);

        // Asynchronous reset mid-frame: outputs clear before any clock edge.
        @(negedge clk);
        din_valid = 1'b0; frame_sync = 1'b0;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'd0);
        chk("async_rst_ecnt2", 32'(err_cnt2), 32'd0);
        $display("mid-frame reset -> locked=%0b slot=%0d dout=%02h", locked, slot, dout);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b1);
            chk_all($sformatf("post_rst%0d", k), 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'd0);
        end

        // Consecutive syncs: first locks, each further one is an early-sync error.
        step(1'b1, 1'b1, 1'b1);
        chk_all("sat_lock", 1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'd0);
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 1'b1, 1'b1);
            chk_all($sformatf("sat%0d", e), 1'b0, 1'b1, 1'b1, 3'd1, 8'h00, 8'(e));
            chk($sformatf("sat%0d_ecnt2", e), 32'(err_cnt2), (e > 3) ? 32'd3 : 32'(e));
            $display("error %0d -> err_cnt=%0d err_cnt(ERR_W=2)=%0d", e, err_cnt, err_cnt2);
        end

        // Finish that frame: slot 0 already holds 1, rest from frame A.
        fe = 8'b01001101;
        for (int k = 1; k < 8; k++) begin
            k1 = (k + 1) % 8;
            step(1'b1, 1'b0, fe[k]);
            chk_all($sformatf("final%0d", k), (k == 7), 1'b0, 1'b1, 3'(k1),
                    (k == 7) ? 8'h4D : 8'h00, 8'd5);
        end
        step(1'b0, 1'b0, 1'b0);
        chk_all("final_idle", 1'b0, 1'b0, 1'b1, 3'd0, 8'h4D, 8'd5);
        $display("final frame -> dout=%02h", dout);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
